i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_target.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and master blocks.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_tgt_state_e;

  typedef enum logic [2:0] {
    M_IDLE,
    M_START,
    M_ADDR,
    M_DATA,
    M_ACK,
    M_STOP
  } i2c_mst_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_ACK  = 4'd8;

  // Open-drain: pulling the line is the only way to put a 0 on it.
  function automatic logic sda_pull(input logic level);
    return ~level;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers, SCL edge strobes and START/STOP detection.
module i2c_bus_sync #(
  parameter int FILTER = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [FILTER-1:0] scl_sync_q;
  logic [FILTER-1:0] sda_sync_q;
  logic              scl_prev_q;
  logic              sda_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[FILTER-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[FILTER-2:0], sda_i};
      scl_prev_q <= scl_o;
      sda_prev_q <= sda_o;
    end
  end

  assign scl_o      = scl_sync_q[FILTER-1];
  assign sda_o      = sda_sync_q[FILTER-1];
  assign scl_rise_o = scl_o & ~scl_prev_q;
  assign scl_fall_o = ~scl_o & scl_prev_q;
  // SDA may only move while SCL is high for START/STOP.
  assign start_o    = scl_o & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_o     = scl_o & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit addressed byte write/read with open-drain SDA.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] OWN_ADDR = 7'h2A,
  parameter int         FILTER   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       rw
);

  logic scl, sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(
    .FILTER(FILTER)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_o     (scl),
    .sda_o     (sda),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  i2c_tgt_state_e state_q;
  logic [3:0]     cnt_q;
  logic [7:0]     shift_q;
  logic [7:0]     byte_in;
  logic           sda_oe_q;
  logic [7:0]     rx_data_q;
  logic           rx_valid_q;
  logic           tx_req_q;
  logic           busy_q;
  logic           rw_q;

  assign byte_in = {shift_q[6:0], sda};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (start) begin
        state_q  <= ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: ;
          ADDR: begin
            if (scl_rise && cnt_q < BIT_ACK) begin
              shift_q <= byte_in;
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == BIT_LAST) begin
                if (byte_in[7:1] == OWN_ADDR) begin
                  rw_q   <= byte_in[0];
                  busy_q <= 1'b1;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end else if (scl_fall && cnt_q == BIT_ACK) begin
              sda_oe_q <= sda_pull(ACK);
              cnt_q    <= '0;
              state_q  <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= '0;
              if (rw_q) begin
                tx_req_q <= 1'b1;
                state_q  <= RD_DATA;
              end else begin
                state_q <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise && cnt_q < BIT_ACK) begin
              shift_q <= byte_in;
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == BIT_LAST) begin
                rx_data_q  <= byte_in;
                rx_valid_q <= 1'b1;
              end
            end else if (scl_fall && cnt_q == BIT_ACK) begin
              sda_oe_q <= sda_pull(ACK);
              cnt_q    <= '0;
              state_q  <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_DATA;
            end
          end
          RD_DATA: begin
            // Capture in the tx_req cycle; drive MSB now only if SCL is low.
            if (tx_req_q) begin
              shift_q <= tx_data;
              if (!scl) sda_oe_q <= sda_pull(tx_data[7]);
            end else if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == BIT_ACK) begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                state_q  <= RD_ACK;
              end else if (cnt_q == 4'd0) begin
                sda_oe_q <= sda_pull(shift_q[7]);
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= sda_pull(shift_q[6]);
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda == ACK) begin
                tx_req_q <= 1'b1;
                cnt_q    <= '0;
                state_q  <= RD_DATA;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign rw       = rw_q;

endmodule
